// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte RAM plus IO transmit FIFO behind a single memory port
// Optional feature: define IO_STATUS_READ_EN to make 32'h00030004 return FIFO status on load.
module mem_responder #(
    parameter int RAM_ADDR_WIDTH = 17,
    parameter int IO_FIFO_DEPTH  = 8
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] mem_a_in,
    input  logic        mem_wr_in,
    input  logic [7:0]  mem_din_in,
    output logic [7:0]  mem_dout,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int PW = $clog2(IO_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] TX_ADDR     = 32'h0003_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h0003_0004;

    logic [7:0]          ram  [0:(2**RAM_ADDR_WIDTH)-1];
    logic [7:0]          fifo [0:IO_FIFO_DEPTH-1];
    logic [PW-1:0]       head;
    logic [PW-1:0]       tail;
    logic [CW-1:0]       count;
    logic                is_io;
    logic                ram_wr;
    logic                push;
    logic                pop;
    logic [7:0]          load_data;
    logic [RAM_ADDR_WIDTH-1:0] ram_idx;

    assign ram_idx        = mem_a_in[RAM_ADDR_WIDTH-1:0];
    assign is_io          = (mem_a_in[17:16] == 2'b11);
    assign ram_wr         = rdy_in && mem_wr_in && !is_io;
    // io_buffer_full is only advisory; a push is refused solely when every slot is taken.
    assign push           = rdy_in && mem_wr_in && (mem_a_in == TX_ADDR) && (count != CW'(IO_FIFO_DEPTH));
    assign pop            = tx_valid && tx_ready;
    assign tx_valid       = (count != '0);
    assign tx_data        = fifo[head];
    assign io_buffer_full = (count >= CW'(IO_FIFO_DEPTH - 1));

    always_comb begin
        load_data = ram[ram_idx];
        if (is_io) begin
            load_data = 8'h00;
`ifdef IO_STATUS_READ_EN
            if (mem_a_in == STATUS_ADDR) begin
                load_data = {io_buffer_full, 3'b000, 4'(count)};
            end
`endif
        end
    end

    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram[ram_idx] <= mem_din_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            fifo[tail] <= mem_din_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            mem_dout <= 8'h00;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            if (rdy_in) begin
                mem_dout <= load_data;
            end
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder (queue/array reference model)
module tb_mem_responder;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  din;
    logic [7:0]  mem_dout;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] q [$];
    logic [7:0] ram_m [int];
    logic [7:0] exp_dout;
    bit         known;

    mem_responder #(.RAM_ADDR_WIDTH(17), .IO_FIFO_DEPTH(DEPTH)) dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .mem_a_in(mem_a),
        .mem_wr_in(mem_wr), .mem_din_in(din), .mem_dout(mem_dout),
        .io_buffer_full(io_buffer_full), .tx_data(tx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        exp_dout = 8'h00;
        known    = 1'b1;
    endtask

    task automatic model_edge();
        bit io;
        bit do_pop;
        bit do_push;
        int idx;
        io  = (mem_a[17:16] == 2'b11);
        idx = int'(mem_a[16:0]);
        if (rst) begin
            model_reset();
            return;
        end
        do_pop  = (q.size() != 0) && tx_ready;
        do_push = rdy && mem_wr && (mem_a == 32'h0003_0000) && (q.size() != DEPTH);
        if (rdy) begin
            if (io) begin
                exp_dout = 8'h00;
                known    = 1'b1;
`ifdef IO_STATUS_READ_EN
                if (mem_a == 32'h0003_0004)
                    exp_dout = ((q.size() >= DEPTH - 1) ? 8'h80 : 8'h00) | 8'(q.size());
`endif
            end else if (ram_m.exists(idx)) begin
                exp_dout = ram_m[idx];
                known    = 1'b1;
            end else begin
                known = 1'b0;
            end
            if (mem_wr && !io) ram_m[idx] = din;
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) q.push_back(din);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic wr_byte(input logic [31:0] addr, input logic [7:0] d);
        mem_wr = 1'b1;
        mem_a  = addr;
        din    = d;
        step();
        mem_wr = 1'b0;
        din    = 8'h00;
    endtask

    task automatic rd_byte(input logic [31:0] addr);
        mem_wr = 1'b0;
        mem_a  = addr;
        step();
    endtask

    // Mid-cycle comparison of every output against the reference model.
    always @(negedge clk) begin
        chk("tx_valid", 32'(tx_valid), 32'(q.size() != 0));
        chk("io_buffer_full", 32'(io_buffer_full), 32'(q.size() >= DEPTH - 1));
        if (q.size() != 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
        if (known) chk("mem_dout", 32'(mem_dout), 32'(exp_dout));
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; mem_a = 32'h0000_0100; mem_wr = 1'b0;
        din = 8'h00; tx_ready = 1'b0;
        model_reset();
        step();
        step();
        chk("reset_tx_valid", 32'(tx_valid), 32'd0);
        chk("reset_full", 32'(io_buffer_full), 32'd0);
        chk("reset_dout", 32'(mem_dout), 32'h00);
        rst = 1'b0;

        // RAM store then load next cycle
        wr_byte(32'h0000_0010, 8'hA5);
        rd_byte(32'h0000_0010);
        chk("ram_readback_a5", 32'(mem_dout), 32'hA5);
        wr_byte(32'h0000_0020, 8'h5A);
        rd_byte(32'h0000_0020);
        chk("ram_readback_5a", 32'(mem_dout), 32'h5A);
        rdy = 1'b0;
        wr_byte(32'h0000_0010, 8'hFF);
        rd_byte(32'h0000_0020);
        chk("rdy_low_holds_dout", 32'(mem_dout), 32'h5A);
        rdy = 1'b1;
        rd_byte(32'h0000_0010);
        chk("rdy_low_no_write", 32'(mem_dout), 32'hA5);
        rd_byte(32'h0003_0008);
        chk("io_load_zero", 32'(mem_dout), 32'h00);
        wr_byte(32'h0003_0001, 8'h77);
        chk("other_io_store_ignored", 32'(tx_valid), 32'd0);

        // Fill FIFO: full rises at 7, 8th push accepted, 9th dropped
        for (int i = 0; i < 7; i++) begin
            wr_byte(32'h0003_0000, 8'(8'h10 + i));
            chk("full_during_fill", 32'(io_buffer_full), 32'(i == 6));
        end
`ifdef IO_STATUS_READ_EN
        rd_byte(32'h0003_0004);
        chk("status_count7", 32'(mem_dout), 32'h87);
`endif
        wr_byte(32'h0003_0000, 8'h17);
        wr_byte(32'h0003_0000, 8'h18);
        tx_ready = 1'b1;
        mem_a = 32'h0000_0100;
        for (int i = 0; i < 8; i++) begin
            chk("drain_order", 32'(tx_data), 32'(8'h10 + i));
            step();
        end
        chk("ninth_push_dropped", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Three pushes then stream out
        wr_byte(32'h0003_0000, 8'h41);
        wr_byte(32'h0003_0000, 8'h42);
        wr_byte(32'h0003_0000, 8'h43);
        tx_ready = 1'b1;
        chk("seq_41", 32'(tx_data), 32'h41);
        step();
        chk("seq_42", 32'(tx_data), 32'h42);
        step();
        chk("seq_43", 32'(tx_data), 32'h43);
        step();
        chk("seq_valid_falls", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Simultaneous push and pop at count 3
        wr_byte(32'h0003_0000, 8'h01);
        wr_byte(32'h0003_0000, 8'h02);
        wr_byte(32'h0003_0000, 8'h03);
        tx_ready = 1'b1;
        wr_byte(32'h0003_0000, 8'h04);
        chk("pp_head2", 32'(tx_data), 32'h02);
        step();
        chk("pp_head3", 32'(tx_data), 32'h03);
        step();
        chk("pp_head4", 32'(tx_data), 32'h04);
        step();
        chk("pp_empty", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // Asynchronous reset mid-cycle with 5 entries queued
        wr_byte(32'h0000_1234, 8'h55);
        for (int i = 0; i < 5; i++) wr_byte(32'h0003_0000, 8'(8'h60 + i));
        rd_byte(32'h0000_1234);
        chk("pre_reset_dout", 32'(mem_dout), 32'h55);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("async_rst_dout", 32'(mem_dout), 32'h00);
        chk("async_rst_full", 32'(io_buffer_full), 32'd0);
        step();
        rst = 1'b0;
        rd_byte(32'h0000_1234);
        chk("ram_survives_reset", 32'(mem_dout), 32'h55);
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
